// File: rtl/key_ctrl_pkg.sv
// Shared types and defaults for the key loader.
// State enum, parity-good constant and default widths.
package key_ctrl_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      CHECK   = 3'd2,
      ARMED   = 3'd3,
      LOCKOUT = 3'd4
   } state_t;

   localparam logic PAR_GOOD     = 1'b0;
   localparam int   KEY_W_DEF    = 8;
   localparam int   MAX_FAIL_DEF = 4;
   localparam int   FAIL_W_DEF   = 3;
endpackage

// File: rtl/key_shift_par.sv
// Serial-in key shifter, bit counter and running-XOR parity.
// Ports: clk, rst (async low), i_clr, i_en, i_sdi -> o_key, o_cnt, o_par.
module key_shift_par
   import key_ctrl_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF,
   parameter int CNT_W = $clog2(KEY_W + 2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_sdi,
   output logic [KEY_W-1:0] o_key,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_par
);
   logic [KEY_W-1:0] r_key;
   logic [CNT_W-1:0] r_cnt;
   logic             r_par;

   // Key bits arrive LSB first, so shift right and
   // insert at the MSB; the parity bit is not stored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_key <= '0;
         r_cnt <= '0;
         r_par <= 1'b0;
      end else if (i_clr) begin
         r_key <= '0;
         r_cnt <= '0;
         r_par <= 1'b0;
      end else if (i_en) begin
         if (r_cnt < CNT_W'(KEY_W))
            r_key <= (r_key >> 1) |
                     (KEY_W'(i_sdi) << (KEY_W - 1));
         r_cnt <= r_cnt + 1'b1;
         r_par <= r_par ^ i_sdi;
      end
   end

   assign o_key = r_key;
   assign o_cnt = r_cnt;
   assign o_par = r_par;
endmodule

// File: rtl/key_load_ctrl.sv
// Key provider: serial parity-checked load, arm, clear, lockout.
// Ports: clk, rst (async low), key_sdi/valid/ready, key_clear,
// keyinput, key_armed, fsm_hold, key_err, lockout; zeroize when
// KEY_ZEROIZE_EN is defined.
module key_load_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int KEY_W    = KEY_W_DEF,
   parameter int MAX_FAIL = MAX_FAIL_DEF,
   parameter int FAIL_W   = FAIL_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_sdi,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic             key_clear,
   output logic [KEY_W-1:0] keyinput,
   output logic             key_armed,
   output logic             fsm_hold,
   output logic             key_err,
`ifdef KEY_ZEROIZE_EN
   input  logic             zeroize,
`endif
   output logic             lockout
);
   localparam int CNT_W = $clog2(KEY_W + 2);

   state_t            r_state;
   state_t            w_next;
   logic [KEY_W-1:0]  r_key;
   logic [FAIL_W-1:0] r_fail;
   logic [FAIL_W-1:0] w_fail_nxt;
   logic              r_run;
   logic [KEY_W-1:0]  w_sh_key;
   logic [CNT_W-1:0]  w_cnt;
   logic              w_par;
   logic              w_xfer;
   logic              w_good;
   logic              w_last;
   logic              w_zero;
   logic              w_zero_act;
   logic              w_clr;

`ifdef KEY_ZEROIZE_EN
   assign w_zero = zeroize;
`else
   assign w_zero = 1'b0;
`endif

   // Zeroize only acts in legal non-lockout states so that an
   // illegal encoding still falls through to LOCKOUT.
   assign w_zero_act = w_zero &&
      (r_state == IDLE || r_state == SHIFT ||
       r_state == CHECK || r_state == ARMED);

   assign w_xfer     = key_valid && key_ready;
   assign w_good     = (w_par == PAR_GOOD);
   assign w_last     = (w_cnt == CNT_W'(KEY_W));
   assign w_fail_nxt = r_fail + 1'b1;
   assign w_clr      = (r_state == CHECK) || w_zero_act;

   key_shift_par #(
      .KEY_W (KEY_W),
      .CNT_W (CNT_W)
   ) u_shift (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_en  (w_xfer && !w_zero_act),
      .i_sdi (key_sdi),
      .o_key (w_sh_key),
      .o_cnt (w_cnt),
      .o_par (w_par)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_xfer) w_next = SHIFT;
         SHIFT:   if (w_xfer && w_last) w_next = CHECK;
         CHECK: begin
            if (w_good)
               w_next = ARMED;
            else if (w_fail_nxt == FAIL_W'(MAX_FAIL))
               w_next = LOCKOUT;
            else
               w_next = IDLE;
         end
         ARMED:   if (key_clear) w_next = IDLE;
         LOCKOUT: w_next = LOCKOUT;
         default: w_next = LOCKOUT;
      endcase
      if (w_zero_act) w_next = IDLE;
   end

   // key_ready is held off for one cycle after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_key  <= '0;
         r_fail <= '0;
         r_run  <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (w_zero_act)
            r_key <= '0;
         else if (r_state == CHECK && w_good)
            r_key <= w_sh_key;
         else if (r_state == ARMED && key_clear)
            r_key <= '0;
         if (r_state == CHECK && !w_good && !w_zero_act &&
             r_fail != FAIL_W'(MAX_FAIL))
            r_fail <= w_fail_nxt;
      end
   end

   always_comb begin
      key_ready = r_run &&
                  (r_state == IDLE || r_state == SHIFT);
      key_armed = (r_state == ARMED);
      fsm_hold  = (r_state != ARMED);
      key_err   = (r_state == CHECK) && !w_good && !w_zero_act;
      lockout   = (r_state == LOCKOUT);
      keyinput  = (r_state == LOCKOUT) ? '0 : r_key;
   end
endmodule

// File: tb/tb_key_load_ctrl.sv
// Self-checking bench for key_load_ctrl with a frame-level model.
// Build with KEY_ZEROIZE_EN defined to also cover zeroize.
module tb_key_load_ctrl;
   localparam int KW = 8;
   localparam int MF = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          key_sdi = 1'b0;
   logic          key_valid = 1'b0;
   logic          key_clear = 1'b0;
   logic          key_ready;
   logic [KW-1:0] keyinput;
   logic          key_armed;
   logic          fsm_hold;
   logic          key_err;
   logic          lockout;
`ifdef KEY_ZEROIZE_EN
   logic          zeroize = 1'b0;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   key_load_ctrl #(.KEY_W(KW), .MAX_FAIL(MF), .FAIL_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_sdi   (key_sdi),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_clear (key_clear),
      .keyinput  (keyinput),
      .key_armed (key_armed),
      .fsm_hold  (fsm_hold),
      .key_err   (key_err),
`ifdef KEY_ZEROIZE_EN
      .zeroize   (zeroize),
`endif
      .lockout   (lockout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Frame-level model: collect the frame as a word, judge it as
   // a whole once complete, track arm/lock/failure totals.
   logic [KW:0]   m_word;
   int            m_n;
   int            m_fails;
   logic          m_pend, m_armed, m_locked, m_run;
   logic [KW-1:0] m_key;
   logic          m_good;
   logic          m_zact;

   assign m_good = ((^m_word) == 1'b0);
`ifdef KEY_ZEROIZE_EN
   assign m_zact = zeroize && !m_locked;
`else
   assign m_zact = 1'b0;
`endif

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_word <= '0; m_n <= 0; m_fails <= 0;
         m_pend <= 0; m_armed <= 0; m_locked <= 0;
         m_run <= 0; m_key <= '0;
      end else begin
         m_run <= 1'b1;
         if (m_locked) begin
         end else if (m_zact) begin
            m_word <= '0; m_n <= 0; m_pend <= 0;
            m_armed <= 0; m_key <= '0;
         end else if (m_pend) begin
            m_pend <= 0; m_n <= 0; m_word <= '0;
            if (m_good) begin
               m_armed <= 1'b1;
               m_key   <= m_word[KW-1:0];
            end else begin
               m_fails <= m_fails + 1;
               if (m_fails + 1 == MF) m_locked <= 1'b1;
            end
         end else if (m_armed) begin
            if (key_clear) begin
               m_armed <= 1'b0; m_key <= '0;
            end
         end else if (m_run && key_valid) begin
            m_word[m_n] <= key_sdi;
            m_n <= m_n + 1;
            if (m_n == KW) m_pend <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("ready",  key_ready,
          m_run && !m_pend && !m_armed && !m_locked);
      chk("armed",  key_armed, m_armed);
      chk("hold",   fsm_hold, !m_armed);
      chk("err",    key_err, m_pend && !m_good && !m_zact);
      chk("lock",   lockout, m_locked);
      chk("keyin",  keyinput, m_armed ? m_key : '0);
   end

   task automatic send_bit(input logic b, input int gaps);
      int to;
      for (int g = 0; g < gaps; g++) begin
         @(negedge clk);
         key_valid = 1'b0;
         key_sdi   = 1'($urandom);
      end
      @(negedge clk);
      key_valid = 1'b1;
      key_sdi   = b;
      to = 0;
      while (!key_ready) begin
         if (to > 50) begin
            n_chk++; n_fail++;
            $display("FAIL xfer_timeout: ready=%0b wanted 1",
                     key_ready);
            key_valid = 1'b0;
            return;
         end
         to++;
         @(negedge clk);
      end
      @(posedge clk);
      #1 key_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [KW-1:0] k,
                             input logic p, input bit stall);
      for (int i = 0; i < KW; i++)
         send_bit(k[i], stall ? int'($urandom_range(0, 2)) : 0);
      send_bit(p, stall ? int'($urandom_range(0, 2)) : 0);
   endtask

   task automatic clear_pulse();
      @(posedge clk); #1 key_clear = 1'b1;
      @(posedge clk); #1 key_clear = 1'b0;
   endtask

   task automatic reset_dut();
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic load_ok(input logic [KW-1:0] k, input string nm);
      send_frame(k, ^k, 1'b0);
      chk({nm, "_check_ready"}, key_ready, 1'b0);
      chk({nm, "_check_armed"}, key_armed, 1'b0);
      @(posedge clk); #1;
      chk({nm, "_key"},   keyinput, k);
      chk({nm, "_armed"}, key_armed, 1'b1);
      chk({nm, "_hold"},  fsm_hold, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", key_ready, 1'b0);
      chk("rst_armed", key_armed, 1'b0);
      chk("rst_hold",  fsm_hold, 1'b1);
      chk("rst_key",   keyinput, 8'h00);
      chk("rst_lock",  lockout, 1'b0);
      chk("rst_err",   key_err, 1'b0);
      rst = 1'b1;

      // 0xA5 has even weight: parity 0
      load_ok(8'hA5, "a5");
      chk("a5_ready", key_ready, 1'b0);
      clear_pulse();
      chk("clr_key",   keyinput, 8'h00);
      chk("clr_armed", key_armed, 1'b0);
      chk("clr_hold",  fsm_hold, 1'b1);
      load_ok(8'h0F, "0f");
      clear_pulse();

      send_frame(8'hA5, 1'b1, 1'b0);
      chk("bad_err", key_err, 1'b1);
      @(posedge clk); #1;
      chk("bad_err_gone", key_err, 1'b0);
      chk("bad_ready",    key_ready, 1'b1);
      chk("bad_key",      keyinput, 8'h00);
      chk("bad_hold",     fsm_hold, 1'b1);

      send_frame(8'h3C, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("stall_key", keyinput, 8'h3C);
      clear_pulse();

      reset_dut();
      for (int k = 0; k < MF; k++) begin
         send_frame(8'h11, 1'b1, 1'b0);
         @(posedge clk); #1;
         chk("lock_step", lockout, k == MF - 1);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); key_valid = 1'b1;
         key_sdi = 1'(c);
         #1 chk("lock_noready", key_ready, 1'b0);
      end
      @(negedge clk); key_valid = 1'b0;
      chk("lock_key",  keyinput, 8'h00);
      chk("lock_hold", fsm_hold, 1'b1);
      rst = 1'b0;
      #1 chk("lock_async_clr", lockout, 1'b0);
      @(negedge clk); rst = 1'b1;

      for (int i = 0; i < 5; i++) send_bit(1'(i), 0);
      #2 rst = 1'b0;
      #1 chk("mid_rst_ready", key_ready, 1'b0);
      @(negedge clk); rst = 1'b1;
      chk("post_rst_ready", key_ready, 1'b0);
      load_ok(8'h81, "81");
      clear_pulse();

`ifdef KEY_ZEROIZE_EN
      reset_dut();
      for (int k = 0; k < MF - 1; k++)
         send_frame(8'h11, 1'b1, 1'b0);
      load_ok(8'h81, "z81");
      @(posedge clk); #1 zeroize = 1'b1;
      @(posedge clk); #1 zeroize = 1'b0;
      chk("zero_key",   keyinput, 8'h00);
      chk("zero_armed", key_armed, 1'b0);
      chk("zero_hold",  fsm_hold, 1'b1);
      send_frame(8'h11, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("zero_failcnt_kept", lockout, 1'b1);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
